// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and data_memory32.
// slave: arbiter view; master: requester/memory side view.
interface dmem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0, req1;
    logic              we0, we1;
    logic              lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational contention resolver used while the arbiter is idle.
// A pending favour (after a forced burst release) or round-robin mode both
// hand the contest to the port that was not granted last.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic lastGnt,
    input  logic favour,
    output logic winner,
    output logic valid
);

    // Pick a winner among the active requesters.
    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CORE;
        if (req0 && req1) begin
            if (favour || RR_EN) winner = ~lastGnt;
            else                 winner = PORT_CORE;
        end else if (req1) begin
            winner = PORT_AUX;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of data_memory32 (port 0 = core, port 1 = aux).
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin contention,
// otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       reset,
    dmem_arb_if.slave  bus
);

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    arb_state_t        state, stateNxt;
    logic [CNT_W-1:0]  lockCnt, lockCntNxt, runCnt;
    logic              lastGnt, lastGntNxt;
    logic              favour, favourNxt;
    logic              pickPort, pickVld;
    logic              gnt0, gnt1;
    logic              xferPort, xferLock;
    logic [ADDR_W-1:0] addrSel;
    logic [DATA_W-1:0] wdataSel;
    logic [DATA_W-1:0] rdata0Q, rdata1Q;
    logic              rvalid0Q, rvalid1Q;

    dmem_arb_pick #(.RR_EN(RR_EN)) uPick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .lastGnt (lastGnt),
        .favour  (favour),
        .winner  (pickPort),
        .valid   (pickVld)
    );

    // State, burst counter, last winner and favour flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            lockCnt <= '0;
            lastGnt <= PORT_AUX;
            favour  <= 1'b0;
        end else begin
            state   <= stateNxt;
            lockCnt <= lockCntNxt;
            lastGnt <= lastGntNxt;
            favour  <= favourNxt;
        end
    end

    // Grants and next state. lockCnt counts locked transfers already done
    // in the current ownership; runCnt is the count including this one, so
    // a burst never exceeds MAX_LOCK transfers in total.
    always_comb begin
        stateNxt   = state;
        lockCntNxt = lockCnt;
        lastGntNxt = lastGnt;
        favourNxt  = favour;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                gnt0 = pickVld && (pickPort == PORT_CORE);
                gnt1 = pickVld && (pickPort == PORT_AUX);
            end
            ARB_OWN0: gnt0 = bus.req0;
            ARB_OWN1: gnt1 = bus.req1;
            default:  ;
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
        xferPort = gnt1;
        xferLock = gnt1 ? bus.lock1 : bus.lock0;
        runCnt   = (state == ARB_IDLE) ? CNT_W'(1)
                 : ((lockCnt == CNT_MAX) ? lockCnt : lockCnt + 1'b1);
        if (gnt0 || gnt1) begin
            lastGntNxt = xferPort;
            if (state == ARB_IDLE) favourNxt = 1'b0;
            if (xferLock && (runCnt < CNT_MAX)) begin
                stateNxt   = xferPort ? ARB_OWN1 : ARB_OWN0;
                lockCntNxt = runCnt;
            end else begin
                stateNxt   = ARB_IDLE;
                lockCntNxt = '0;
                if (xferLock) favourNxt = 1'b1;
            end
        end else if (state != ARB_IDLE) begin
            stateNxt   = ARB_IDLE;
            lockCntNxt = '0;
        end
    end

    // Read responses: capture memory data at the transfer edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0Q <= 1'b0;
            rvalid1Q <= 1'b0;
            rdata0Q  <= '0;
            rdata1Q  <= '0;
        end else begin
            rvalid0Q <= gnt0 & ~bus.we0;
            rvalid1Q <= gnt1 & ~bus.we1;
            if (gnt0 && !bus.we0) rdata0Q <= bus.mem_rdata;
            if (gnt1 && !bus.we1) rdata1Q <= bus.mem_rdata;
        end
    end

    assign addrSel  = gnt1 ? bus.addr1  : (gnt0 ? bus.addr0  : '0);
    assign wdataSel = gnt1 ? bus.wdata1 : (gnt0 ? bus.wdata0 : '0);

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_we    = (gnt0 & bus.we0) | (gnt1 & bus.we1);
    assign bus.mem_addr  = addrSel;
    assign bus.mem_wdata = wdataSel;
    assign bus.rvalid0   = rvalid0Q;
    assign bus.rvalid1   = rvalid1Q;
    assign bus.rdata0    = rdata0Q;
    assign bus.rdata1    = rdata1Q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// all cycles checked against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int ML = 4;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: combinational read, write on the rising edge.
    logic [31:0] mem [64] = '{default: '0};
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

    // Requester drive arrays.
    logic        pReq [2];
    logic        pWe  [2];
    logic        pLock[2];
    logic [31:0] pAddr[2];
    logic [31:0] pData[2];
    assign bus.req0 = pReq[0];   assign bus.req1 = pReq[1];
    assign bus.we0 = pWe[0];     assign bus.we1 = pWe[1];
    assign bus.lock0 = pLock[0]; assign bus.lock1 = pLock[1];
    assign bus.addr0 = pAddr[0]; assign bus.addr1 = pAddr[1];
    assign bus.wdata0 = pData[0]; assign bus.wdata1 = pData[1];

    // Reference model: owner of the bus (-1 none), locked transfers in the
    // current ownership, last winner, favour pending, expected responses.
    int          refOwner, refRun, refLast;
    bit          refFav;
    bit          refRv[2];
    logic [31:0] refRd[2];
    logic [31:0] refMem[64];

    int nChk = 0, nPass = 0;
    int lastW;
    logic gotG0, gotG1, gotWe;
    logic [31:0] gotAddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int expWinner();
        if (reset) return -1;
        if (refOwner >= 0) return pReq[refOwner] ? refOwner : -1;
        if (pReq[0] && pReq[1]) return (refFav || RR) ? 1 - refLast : 0;
        if (pReq[0]) return 0;
        if (pReq[1]) return 1;
        return -1;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    task automatic modelReset();
        refOwner = -1; refRun = 0; refLast = 1; refFav = 1'b0;
        refRv[0] = 1'b0; refRv[1] = 1'b0;
        refRd[0] = '0;   refRd[1] = '0;
    endtask

    // One clock cycle: check the combinational bus, advance, check responses.
    task automatic step();
        int w;
        logic expWe;
        logic [31:0] expAddr, expData;
        #1;
        w = expWinner();
        expWe = 1'b0; expAddr = '0; expData = '0;
        if (w >= 0) begin expWe = pWe[w]; expAddr = pAddr[w]; expData = pData[w]; end
        gotG0 = bus.gnt0; gotG1 = bus.gnt1; gotWe = bus.mem_we; gotAddr = bus.mem_addr;
        chk("gnt0", 32'(bus.gnt0), 32'(w == 0));
        chk("gnt1", 32'(bus.gnt1), 32'(w == 1));
        chk("mem_we", 32'(bus.mem_we), 32'(expWe));
        chk("mem_addr", bus.mem_addr, expAddr);
        chk("mem_wdata", bus.mem_wdata, expData);
        @(posedge clk);
        if (reset) modelReset();
        else begin
            refRv[0] = 1'b0; refRv[1] = 1'b0;
            if (w >= 0) begin
                refLast = w;
                if (pWe[w]) refMem[widx(pAddr[w])] = pData[w];
                else begin refRv[w] = 1'b1; refRd[w] = refMem[widx(pAddr[w])]; end
                if (refOwner < 0) begin refRun = 1; refFav = 1'b0; end
                else refRun++;
                if (pLock[w] && refRun < ML) refOwner = w;
                else begin
                    if (pLock[w]) refFav = 1'b1;
                    refOwner = -1;
                end
            end else refOwner = -1;
        end
        lastW = w;
        #1;
        chk("rvalid0", 32'(bus.rvalid0), 32'(refRv[0]));
        chk("rvalid1", 32'(bus.rvalid1), 32'(refRv[1]));
        chk("rdata0", bus.rdata0, refRd[0]);
        chk("rdata1", bus.rdata1, refRd[1]);
    endtask

    task automatic setReq(input int p, input logic we, input logic lk,
                          input logic [31:0] a, input logic [31:0] d);
        pReq[p] = 1'b1; pWe[p] = we; pLock[p] = lk; pAddr[p] = a; pData[p] = d;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) refMem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            pReq[p] = 1'b0; pWe[p] = 1'b0; pLock[p] = 1'b0; pAddr[p] = '0; pData[p] = '0;
        end
        modelReset();
        lastW = -1;

        // Reset state.
        reset = 1'b1;
        step();
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("rst_rdata1", bus.rdata1, 32'd0);
        reset = 1'b0;
        step();

        // Uncontested write then uncontested read on port 1.
        setReq(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        step();
        pReq[0] = 1'b0;
        setReq(1, 1'b0, 1'b0, 32'h40, 32'h0);
        step();
        chk("t1_gnt1", 32'(gotG1), 32'd1);
        chk("t1_addr", gotAddr, 32'h40);
        chk("t1_rvalid1", 32'(bus.rvalid1), 32'd1);
        chk("t1_rdata1", bus.rdata1, 32'hDEADBEEF);
        pReq[1] = 1'b0;
        step();
        chk("t1_rvalid1_off", 32'(bus.rvalid1), 32'd0);

        // Simultaneous writes: port 0 first, port 1 the very next cycle.
        setReq(0, 1'b1, 1'b0, 32'h10, 32'h11);
        setReq(1, 1'b1, 1'b0, 32'h20, 32'h22);
        step();
        chk("t2_first_g0", 32'(gotG0), 32'd1);
        chk("t2_first_we", 32'(gotWe), 32'd1);
        pReq[0] = 1'b0;
        step();
        chk("t2_second_g1", 32'(gotG1), 32'd1);
        chk("t2_second_we", 32'(gotWe), 32'd1);
        pReq[1] = 1'b0;

        // Port 0 streaming: port 1 gets in only under round-robin.
        setReq(1, 1'b1, 1'b0, 32'h24, 32'h33);
        for (int c = 0; c < 3; c++) begin
            setReq(0, 1'b1, 1'b0, 32'h14, 32'h100 + 32'(c));
            step();
            chk("t2b_g1", 32'(gotG1), 32'(RR && c == 1));
            chk("t2b_g0", 32'(gotG0), 32'(!(RR && c == 1)));
            if (gotG1) pReq[1] = 1'b0;
        end
        pReq[0] = 1'b0;
        if (pReq[1]) begin
            step();
            chk("t2b_late_g1", 32'(gotG1), 32'd1);
            pReq[1] = 1'b0;
        end
        step();

        // Locked burst on port 1 against a waiting port 0.
        setReq(1, 1'b0, 1'b1, 32'h40, 32'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_g1", 32'(gotG1), 32'(c < 4));
            chk("t3_g0", 32'(gotG0), 32'(c == 4));
            if (c == 0) setReq(0, 1'b0, 1'b0, 32'h10, 32'h0);
        end
        pReq[0] = 1'b0; pReq[1] = 1'b0;
        step();

        // Port 0 lock dropped by deasserting req0 mid-burst.
        setReq(0, 1'b1, 1'b1, 32'h08, 32'hA5A50008);
        step();
        chk("t4_g0_a", 32'(gotG0), 32'd1);
        setReq(1, 1'b0, 1'b0, 32'h08, 32'h0);
        step();
        chk("t4_g0_b", 32'(gotG0), 32'd1);
        chk("t4_g1_b", 32'(gotG1), 32'd0);
        pReq[0] = 1'b0;
        step();
        chk("t4_nogrant", 32'({gotG0, gotG1}), 32'd0);
        step();
        chk("t4_g1_c", 32'(gotG1), 32'd1);
        chk("t4_rdata1", bus.rdata1, 32'hA5A50008);
        pReq[1] = 1'b0;

        // Reset on a write-grant cycle.
        setReq(0, 1'b1, 1'b0, 32'h3C, 32'hCAFEF00D);
        reset = 1'b1;
        step();
        chk("t5_we", 32'(gotWe), 32'd0);
        chk("t5_g0", 32'(gotG0), 32'd0);
        chk("t5_rdata0", bus.rdata0, 32'd0);
        reset = 1'b0;
        pReq[0] = 1'b0;
        step();
        setReq(1, 1'b0, 1'b0, 32'h3C, 32'h0);
        step();
        chk("t5_mem_kept", bus.rdata1, 32'd0);
        pReq[1] = 1'b0;

        // Read then immediate write on port 0.
        setReq(0, 1'b0, 1'b0, 32'h40, 32'h0);
        step();
        chk("t6_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("t6_rdata0", bus.rdata0, 32'hDEADBEEF);
        setReq(0, 1'b1, 1'b0, 32'h40, 32'h12345678);
        step();
        chk("t6_rvalid0_wr", 32'(bus.rvalid0), 32'd0);
        chk("t6_rdata0_held", bus.rdata0, 32'hDEADBEEF);
        pReq[0] = 1'b0;
        step();

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pReq[p] || lastW == p) begin
                    if ($urandom_range(0, 3) != 0)
                        setReq(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               32'($urandom_range(0, 15)) << 2, $urandom);
                    else pReq[p] = 1'b0;
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
